// File: rtl/mc_decoder_pkg.sv
// Shared opcode encodings, decoder state type and opcode legality check.
package mc_decoder_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OPC_W-1:0] OP_STORE = 4'd1;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd2;
    localparam logic [OPC_W-1:0] OP_BNE   = 4'd3;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'd4;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'd5;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'd6;
    localparam logic [OPC_W-1:0] OP_XOR   = 4'd7;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'd8;
    localparam logic [OPC_W-1:0] OP_AND   = 4'd9;
    localparam logic [OPC_W-1:0] OP_OR    = 4'd10;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'd11;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    // Low opcode nibble is defined: 0..11 and HALT; 12..14 are holes.
    function automatic logic is_legal(input logic [OPC_W-1:0] opc);
        return (opc <= OP_JMP) || (opc == OP_HALT);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the last permitted one.
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic clock,
    input  logic n_reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int unsigned CNT_W      = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int unsigned THRESH     = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
    localparam bit          TIMEOUT_EN = (WAIT_MAX != 0);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    // Next count: clear wins, otherwise count waits and saturate at all-ones.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (waiting && (wait_cnt_q != {CNT_W{1'b1}})) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Expiry only on a cycle that is still waiting at the threshold count.
    assign expired = TIMEOUT_EN && waiting && (wait_cnt_q == CNT_W'(THRESH));

endmodule

// File: rtl/mc_decoder.sv
// Multi-cycle control decoder: fetch/execute sequencing, memory wait
// states with timeout, run/halt control and Mealy datapath enables.
module mc_decoder
    import mc_decoder_pkg::*;
#(
    parameter int unsigned OP_W     = 4,
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic            run,
    input  logic            z_flag,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            load_IR,
    output logic            load_REG,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            ALU_REG,
    output logic            IMM,
    output logic            WE,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_xor,
    output logic            ALU_and,
    output logic            ALU_or,
    output logic            retire,
    output logic            halted,
    output logic            illegal_op,
    output logic            bus_error
);

    state_e           state_q;
    state_e           state_d;
    logic             bus_error_q;
    logic             bus_error_d;
    logic [OPC_W-1:0] op_lo;
    logic             upper_nz;
    logic             op_ok;
    logic             is_mem_op;
    logic             waiting;
    logic             timer_clear;
    logic             expired;

    assign op_lo = op[OPC_W-1:0];

    // Any set bit above the 4-bit opcode field makes the opcode undefined.
    generate
        if (OP_W > OPC_W) begin : g_upper
            assign upper_nz = |op[OP_W-1:OPC_W];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    assign op_ok     = is_legal(op_lo) && !upper_nz;
    assign is_mem_op = op_ok && ((op_lo == OP_LOAD) || (op_lo == OP_STORE));

    // Memory request depends only on state and opcode, keeping the timer path acyclic.
    always_comb begin
        mem_req = 1'b0;
        if (state_q == ST_FETCH) begin
            mem_req = 1'b1;
        end else if ((state_q == ST_EXECUTE) && is_mem_op) begin
            mem_req = 1'b1;
        end
    end

    assign waiting     = mem_req && !mem_ready;
    assign timer_clear = (state_d != state_q) || (mem_req && mem_ready);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clock   (clock),
        .n_reset (n_reset),
        .clear   (timer_clear),
        .waiting (waiting),
        .expired (expired)
    );

    // Next-state and datapath enable decode.
    always_comb begin
        state_d     = state_q;
        bus_error_d = bus_error_q;
        load_IR     = 1'b0;
        load_REG    = 1'b0;
        load_PC     = 1'b0;
        INC_PC      = 1'b0;
        ALU_REG     = 1'b0;
        IMM         = 1'b0;
        WE          = 1'b0;
        ALU_add     = 1'b0;
        ALU_sub     = 1'b0;
        ALU_xor     = 1'b0;
        ALU_and     = 1'b0;
        ALU_or      = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (mem_ready) begin
                    load_IR = 1'b1;
                    state_d = ST_EXECUTE;
                end else if (expired) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_HALT;
                end
            end

            ST_EXECUTE: begin
                if (is_mem_op) begin
                    WE = (op_lo == OP_STORE);
                    if (mem_ready) begin
                        load_REG = (op_lo == OP_LOAD);
                        load_PC  = 1'b1;
                        INC_PC   = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else if (expired) begin
                        bus_error_d = 1'b1;
                        state_d     = ST_HALT;
                    end
                end else begin
                    load_PC = 1'b1;
                    INC_PC  = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                    if (!op_ok) begin
                        illegal_op = 1'b1;
                    end else begin
                        unique case (op_lo)
                            OP_BNE:  INC_PC = z_flag;
                            OP_BEQ:  INC_PC = !z_flag;
                            OP_JMP:  INC_PC = 1'b0;
                            OP_ADD:  begin load_REG = 1'b1; ALU_REG = 1'b1; ALU_add = 1'b1; end
                            OP_SUB:  begin load_REG = 1'b1; ALU_REG = 1'b1; ALU_sub = 1'b1; end
                            OP_ADDI: begin load_REG = 1'b1; ALU_REG = 1'b1; ALU_add = 1'b1; IMM = 1'b1; end
                            OP_XOR:  begin load_REG = 1'b1; ALU_REG = 1'b1; ALU_xor = 1'b1; end
                            OP_AND:  begin load_REG = 1'b1; ALU_REG = 1'b1; ALU_and = 1'b1; end
                            OP_OR:   begin load_REG = 1'b1; ALU_REG = 1'b1; ALU_or  = 1'b1; end
                            OP_HALT: state_d = ST_HALT;
                            default: ;
                        endcase
                    end
                end
            end

            ST_HALT: begin
                halted = 1'b1;
                if (run) begin
                    bus_error_d = 1'b0;
                    state_d     = ST_FETCH;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and sticky bus error registers.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mc_decoder.sv
// Directed bench for mc_decoder: stimulus queues expected output vectors,
// a negedge monitor pops and compares them.
module tb_mc_decoder;

    localparam int unsigned OP_W = 5;

    localparam logic [16:0] MREQ = 17'h10000;
    localparam logic [16:0] LIR  = 17'h08000;
    localparam logic [16:0] LREG = 17'h04000;
    localparam logic [16:0] LPC  = 17'h02000;
    localparam logic [16:0] INC  = 17'h01000;
    localparam logic [16:0] AREG = 17'h00800;
    localparam logic [16:0] IMMB = 17'h00400;
    localparam logic [16:0] WEB  = 17'h00200;
    localparam logic [16:0] ADD  = 17'h00100;
    localparam logic [16:0] SUB  = 17'h00080;
    localparam logic [16:0] XORB = 17'h00040;
    localparam logic [16:0] ANDB = 17'h00020;
    localparam logic [16:0] ORB  = 17'h00010;
    localparam logic [16:0] RET  = 17'h00008;
    localparam logic [16:0] HLT  = 17'h00004;
    localparam logic [16:0] ILL  = 17'h00002;
    localparam logic [16:0] BERR = 17'h00001;
    localparam logic [16:0] NONE = 17'h00000;

    localparam logic [16:0] E_FETCH = MREQ | LIR;
    localparam logic [16:0] E_SEQ   = LPC | INC | RET;
    localparam logic [16:0] E_TAKEN = LPC | RET;

    logic            clock;
    logic            n_reset;
    logic            run;
    logic            z_flag;
    logic [OP_W-1:0] op;
    logic            mem_ready;
    logic            mem_req, load_IR, load_REG, load_PC, INC_PC, ALU_REG, IMM, WE;
    logic            ALU_add, ALU_sub, ALU_xor, ALU_and, ALU_or;
    logic            retire, halted, illegal_op, bus_error;

    logic [16:0] exp_q[$];
    string       name_q[$];
    int          n_cmp;
    int          n_err;

    mc_decoder #(
        .OP_W     (OP_W),
        .WAIT_MAX (8)
    ) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .run        (run),
        .z_flag     (z_flag),
        .op         (op),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .load_IR    (load_IR),
        .load_REG   (load_REG),
        .load_PC    (load_PC),
        .INC_PC     (INC_PC),
        .ALU_REG    (ALU_REG),
        .IMM        (IMM),
        .WE         (WE),
        .ALU_add    (ALU_add),
        .ALU_sub    (ALU_sub),
        .ALU_xor    (ALU_xor),
        .ALU_and    (ALU_and),
        .ALU_or     (ALU_or),
        .retire     (retire),
        .halted     (halted),
        .illegal_op (illegal_op),
        .bus_error  (bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: compare the DUT outputs mid-cycle against the queued expectation.
    always @(negedge clock) begin
        logic [16:0] act;
        logic [16:0] e;
        string       nm;
        act = {mem_req, load_IR, load_REG, load_PC, INC_PC, ALU_REG, IMM, WE,
               ALU_add, ALU_sub, ALU_xor, ALU_and, ALU_or,
               retire, halted, illegal_op, bus_error};
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %05h expected %05h", nm, act, e);
            end
        end
    end

    // One cycle of stimulus plus its expected output vector.
    task automatic step(input logic r, input logic z, input logic [OP_W-1:0] o,
                        input logic rdy, input logic [16:0] e, input string nm);
        run       = r;
        z_flag    = z;
        op        = o;
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    // Zero-wait fetch followed by a single execute cycle.
    task automatic instr(input logic [OP_W-1:0] o, input logic z,
                         input logic [16:0] e, input string nm);
        step(1'b0, 1'b0, o, 1'b1, E_FETCH, {nm, "_fetch"});
        step(1'b0, z, o, 1'b1, e, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_reset = 1'b0;
        run = 1'b0; z_flag = 1'b0; op = '0; mem_ready = 1'b0;
        @(posedge clock);
        #1;

        // Outputs stay low while held in reset even with run and ready high.
        step(1'b1, 1'b1, 5'd4, 1'b1, NONE, "in_reset");
        n_reset = 1'b1;
        step(1'b0, 1'b0, 5'd0, 1'b1, NONE, "idle_no_run");
        step(1'b1, 1'b0, 5'd0, 1'b1, NONE, "idle_run");

        // ADD then HALT with zero-wait memory.
        instr(5'd4, 1'b0, LREG | AREG | ADD | E_SEQ, "add");
        instr(5'd15, 1'b0, E_SEQ, "halt_op");
        step(1'b0, 1'b0, 5'd0, 1'b1, HLT, "halted");
        step(1'b1, 1'b0, 5'd0, 1'b1, HLT, "halted_resume");

        // Branches.
        instr(5'd3,  1'b0, E_TAKEN, "bne_taken");
        instr(5'd3,  1'b1, E_SEQ,   "bne_not_taken");
        instr(5'd8,  1'b1, E_TAKEN, "beq_taken");
        instr(5'd8,  1'b0, E_SEQ,   "beq_not_taken");
        instr(5'd11, 1'b0, E_TAKEN, "jmp_z0");
        instr(5'd11, 1'b1, E_TAKEN, "jmp_z1");

        // Remaining ALU ops and NOP.
        instr(5'd5,  1'b0, LREG | AREG | SUB | E_SEQ,         "sub");
        instr(5'd6,  1'b1, LREG | AREG | ADD | IMMB | E_SEQ,  "addi");
        instr(5'd7,  1'b0, LREG | AREG | XORB | E_SEQ,        "xor");
        instr(5'd9,  1'b0, LREG | AREG | ANDB | E_SEQ,        "and");
        instr(5'd10, 1'b0, LREG | AREG | ORB | E_SEQ,         "or");
        instr(5'd0,  1'b0, E_SEQ,                             "nop");

        // Undefined opcodes behave as NOP and pulse illegal_op.
        instr(5'd13,       1'b0, E_SEQ | ILL, "illegal_13");
        instr(5'b10100,    1'b0, E_SEQ | ILL, "illegal_upper_add");
        instr(5'b10001,    1'b0, E_SEQ | ILL, "illegal_upper_store");

        // LOAD with three wait cycles.
        step(1'b0, 1'b0, 5'd2, 1'b1, E_FETCH, "load_fetch");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd2, 1'b0, MREQ, "load_wait");
        step(1'b0, 1'b0, 5'd2, 1'b1, MREQ | LREG | E_SEQ, "load_done");

        // Fetch with two waits, then zero-wait STORE.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 5'd1, 1'b0, MREQ, "fetch_wait");
        step(1'b0, 1'b0, 5'd1, 1'b1, E_FETCH, "fetch_after_wait");
        step(1'b0, 1'b0, 5'd1, 1'b1, MREQ | WEB | E_SEQ, "store_done");

        // Ready arriving on the threshold wait cycle completes without error.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 5'd0, 1'b0, MREQ, "thresh_wait");
        step(1'b0, 1'b0, 5'd0, 1'b1, E_FETCH, "thresh_ready");
        step(1'b0, 1'b0, 5'd0, 1'b1, E_SEQ, "thresh_nop");

        // STORE never acknowledged: eight WE cycles then HALT with bus_error.
        step(1'b0, 1'b0, 5'd1, 1'b1, E_FETCH, "to_fetch");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 5'd1, 1'b0, MREQ | WEB, "to_store_wait");
        step(1'b0, 1'b0, 5'd1, 1'b0, HLT | BERR, "to_halted");
        step(1'b1, 1'b0, 5'd1, 1'b0, HLT | BERR, "to_resume");
        step(1'b0, 1'b0, 5'd1, 1'b0, MREQ, "to_fetch_cleared");

        // Asynchronous reset during a fetch wait.
        step(1'b0, 1'b0, 5'd1, 1'b0, MREQ, "pre_reset_wait");
        n_reset = 1'b0;
        step(1'b1, 1'b0, 5'd4, 1'b1, NONE, "async_reset");
        step(1'b1, 1'b0, 5'd4, 1'b1, NONE, "reset_held");
        n_reset = 1'b1;
        step(1'b0, 1'b0, 5'd4, 1'b1, NONE, "post_reset_idle");
        step(1'b0, 1'b0, 5'd4, 1'b1, NONE, "post_reset_idle2");
        step(1'b1, 1'b0, 5'd4, 1'b1, NONE, "post_reset_run");
        instr(5'd0, 1'b0, E_SEQ, "post_reset_nop");

        repeat (2) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_decoder.md
# mc_decoder

Multi-cycle control decoder for the basic processor, successor to the two-state fetch/execute decoder. Drives the same register, PC, IR, ALU and memory-write enables, and adds: parametrised opcode width, a larger instruction set (BEQ, AND, OR, JMP, HALT, NOP), a memory ready handshake with wait states and timeout, and run/halt control. Sits between the IR opcode field / ALU zero flag and the datapath and memory.

## Interface
- OP_W, 4, opcode width; legal range ≥ 4; opcode bits above bit 3 must be zero.
- WAIT_MAX, 8, maximum consecutive wait cycles per memory access; 0 disables the timeout.
- clock  input  1  system clock, rising edge.
- n_reset  input  1  reset; one clock; reset is asynchronous and active-low.
- run  input  1  start/resume request, sampled in IDLE and HALT.
- z_flag  input  1  ALU zero flag.
- op  input  OP_W  opcode from IR.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access in progress (fetch, load or store).
- load_IR, load_REG, load_PC, INC_PC, ALU_REG, IMM, WE  output  1 each  datapath enables, same meaning as the existing decoder.
- ALU_add, ALU_sub, ALU_xor, ALU_and, ALU_or  output  1 each  one-hot ALU function select (all 0 = pass).
- retire  output  1  one-cycle pulse on the instruction's completion cycle.
- halted  output  1  high in HALT.
- illegal_op  output  1  one-cycle pulse on completion of an undefined opcode.
- bus_error  output  1  registered sticky flag: memory timeout.

## Operation
- States: IDLE (reset), FETCH, EXECUTE, HALT.
- IDLE: all outputs 0. If run=1, go to FETCH.
- FETCH: mem_req=1. If mem_ready=1, assert load_IR and go to EXECUTE. Otherwise stay, with load_IR=0.
- EXECUTE, non-memory ops: completes in one cycle. Asserts retire and load_PC. INC_PC=1 unless a branch is taken. Next state is FETCH, or HALT for the HALT opcode.
- EXECUTE, LOAD/STORE: mem_req=1, plus WE=1 for STORE, held while waiting. Completion is the cycle mem_ready=1. In that cycle assert load_PC, INC_PC, retire, and load_REG for LOAD. During wait cycles, load_PC, INC_PC, load_REG and retire are all 0.
- Opcodes (shared package):
  - 0 NOP: PC increment only.
  - 1 STORE, 2 LOAD.
  - 3 BNE: taken when z_flag=0.
  - 4 ADD, 5 SUB, 6 ADDI (IMM=1, add), 7 XOR.
  - 8 BEQ: taken when z_flag=1.
  - 9 AND, 10 OR.
  - 11 JMP: always taken.
  - 15 HALT.
- ALU ops (ADD, SUB, ADDI, XOR, AND, OR): load_REG=1, ALU_REG=1, plus the matching ALU_* select.
- Taken branch: load_PC=1, INC_PC=0, so the PC loads the target.
- Undefined opcodes (12–14, or any nonzero upper bit) execute as NOP and pulse illegal_op.
- HALT state: halted=1, all other enables 0. run=1 → FETCH and clears bus_error. The PC was already incremented, so execution resumes after the HALT instruction.
- Timeout: wait_cnt counts cycles with mem_req=1 and mem_ready=0. It clears on every accepted access and on every state change.
  - If WAIT_MAX>0, wait_cnt==WAIT_MAX-1 and mem_ready=0: set bus_error and go to HALT next cycle. No load_IR, WE completion, PC update or retire occurs.
  - wait_cnt width is $clog2(WAIT_MAX+1). It saturates and does not wrap when WAIT_MAX=0.

## Timing
- All enables are combinational (Mealy) from state, op, z_flag and mem_ready. State, wait_cnt and bus_error are registered.
- Zero-wait memory:
  - ALU/branch/NOP instruction: 2 cycles.
  - LOAD/STORE: 2 cycles.
  - Each wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.
- mem_ready in the same cycle as the timeout threshold: the access completes normally, with no error.
- Reset asserted mid-access: state goes to IDLE immediately, all outputs drop to 0 asynchronously, wait_cnt=0, bus_error=0.
- Outputs in reset: all 0, state IDLE.

## Structure
- Package mc_decoder_pkg holds:
  - the opcode localparams (4-bit values above);
  - the state enum type;
  - a function is_legal(op).
- Sub-module mem_wait_timer: wait_cnt counter and timeout compare. Inputs: clock, n_reset, clear, waiting. Output: expired. Parameter: WAIT_MAX.
- Top level: state register, bus_error register, combinational decode.

## Test plan
- Reset then run=1, mem_ready tied 1, program ADD, HALT → load_IR at cycles 1 and 3; ADD execute shows load_REG=ALU_REG=ALU_add=1 and retire; then halted=1.
- BNE with z_flag=0 → load_PC=1, INC_PC=0. BNE with z_flag=1 → INC_PC=1. BEQ, the inverse → correct. JMP → INC_PC=0 regardless of z_flag.
- LOAD with mem_ready held low 3 cycles → 3 wait cycles with mem_req=1 and load_REG=0; on the 4th cycle load_REG=load_PC=INC_PC=retire=1.
- WAIT_MAX=8, STORE with mem_ready never asserted → WE=1 for 8 cycles; bus_error=1 and halted=1 from cycle 9; run=1 → FETCH and bus_error=0.
- op=13 and op=5'b10100 (OP_W=5) → PC increment, illegal_op pulse, no load_REG or WE.
- n_reset low during a fetch wait → state IDLE and all outputs 0 within the same cycle; no activity until run=1.
